// File: rtl/lms_gear_ctrl.sv
// lms_gear_ctrl: adaptation sequencer for the LMS equalizer.
// Gear-shifts mu downward during acquisition, tracks at the smallest mu,
// freezes coefficient updates once the windowed |error| sum is low, and
// re-acquires automatically when the windowed |error| sum rises again.
module lms_gear_ctrl #(
    parameter int ERR_BW   = 8,
    parameter int MU_BW    = 8,
    parameter int CNT_BW   = 20,
    parameter int N_GEARS  = 4,
    parameter int WIN_LOG2 = 4,
    localparam int SUM_BW  = ERR_BW + WIN_LOG2
) (
    input  logic                     clockdsp,
    input  logic                     soft_reset,
    input  logic                     i_en,
    input  logic                     i_start,
    input  logic                     i_stop,
    input  logic signed [ERR_BW-1:0] i_error,
    input  logic [MU_BW-1:0]         i_mu_init,
    input  logic [CNT_BW-1:0]        i_gear_len,
    input  logic [SUM_BW-1:0]        i_freeze_thr,
    input  logic [SUM_BW-1:0]        i_relock_thr,
    output logic [MU_BW-1:0]         o_mu,
    output logic                     o_lms_en,
    output logic [1:0]               o_state,
    output logic [1:0]               o_gear,
    output logic                     o_locked,
    output logic [SUM_BW-1:0]        o_err_sum,
    output logic                     o_err_sum_vld
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2,
        ST_FREEZE  = 2'd3
    } state_t;

    localparam logic [1:0] GEAR_LAST = 2'(N_GEARS - 1);

    state_t              state_q,    state_d;
    logic [1:0]          gear_q,     gear_d;
    logic [CNT_BW-1:0]   gear_cnt_q, gear_cnt_d;
    logic [MU_BW-1:0]    mu_cap_q,   mu_cap_d;
    logic [WIN_LOG2-1:0] win_cnt_q,  win_cnt_d;
    logic [SUM_BW-1:0]   acc_q,      acc_d;
    logic [SUM_BW-1:0]   sum_q,      sum_d;
    logic                sum_vld_q,  sum_vld_d;
    state_t              sum_src_q,  sum_src_d;
    logic [MU_BW-1:0]    mu_q,       mu_d;
    logic                lms_en_q,   lms_en_d;
    logic                locked_q,   locked_d;

    logic [SUM_BW-1:0]   err_sx;
    logic [SUM_BW-1:0]   abs_err;
    logic [SUM_BW-1:0]   acc_add;
    logic [CNT_BW-1:0]   gear_last_cnt;
    logic                sum_hit;
    logic                enter;

    assign err_sx        = {{WIN_LOG2{i_error[ERR_BW-1]}}, i_error};
    // -128 maps to +128; the extra WIN_LOG2 bits leave room for it
    assign abs_err       = i_error[ERR_BW-1] ? (~err_sx + SUM_BW'(1)) : err_sx;
    assign acc_add       = acc_q + abs_err;
    // A gear length of zero behaves like a length of one
    assign gear_last_cnt = (i_gear_len == '0) ? '0 : (i_gear_len - CNT_BW'(1));
    // Only a window completed in the current state may trigger a transition,
    // so a window that closed during ACQUIRE never freezes TRACK
    assign sum_hit       = sum_vld_q && (sum_src_q == state_q);

    // Next-state, window accumulation and registered-output decode
    always_comb begin
        state_d    = state_q;
        gear_d     = gear_q;
        gear_cnt_d = gear_cnt_q;
        mu_cap_d   = mu_cap_q;
        win_cnt_d  = win_cnt_q;
        acc_d      = acc_q;
        sum_d      = sum_q;
        sum_vld_d  = 1'b0;
        sum_src_d  = sum_src_q;
        enter      = 1'b0;

        if (state_q != ST_IDLE && i_en) begin
            if (win_cnt_q == '1) begin
                sum_d     = acc_add;
                sum_vld_d = 1'b1;
                sum_src_d = state_q;
                acc_d     = '0;
                win_cnt_d = '0;
            end else begin
                acc_d     = acc_add;
                win_cnt_d = win_cnt_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d    = ST_ACQUIRE;
                    gear_d     = '0;
                    gear_cnt_d = '0;
                    mu_cap_d   = i_mu_init;
                    enter      = 1'b1;
                end
            end
            ST_ACQUIRE: begin
                if (i_en) begin
                    if (gear_cnt_q == gear_last_cnt) begin
                        gear_cnt_d = '0;
                        if (gear_q < GEAR_LAST) begin
                            gear_d = gear_q + 1'b1;
                        end else begin
                            state_d = ST_TRACK;
                            enter   = 1'b1;
                        end
                    end else begin
                        gear_cnt_d = gear_cnt_q + 1'b1;
                    end
                end
            end
            ST_TRACK: begin
                if (sum_hit && (sum_q < i_freeze_thr)) begin
                    state_d = ST_FREEZE;
                    enter   = 1'b1;
                end
            end
            ST_FREEZE: begin
                if (sum_hit && (sum_q > i_relock_thr)) begin
                    state_d    = ST_ACQUIRE;
                    gear_d     = '0;
                    gear_cnt_d = '0;
                    enter      = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Entering a state restarts the window; an already latched sum is kept
        if (enter) begin
            win_cnt_d = '0;
            acc_d     = '0;
        end

        if (i_stop) begin
            state_d    = ST_IDLE;
            gear_d     = '0;
            gear_cnt_d = '0;
            mu_cap_d   = '0;
            win_cnt_d  = '0;
            acc_d      = '0;
            sum_d      = '0;
            sum_vld_d  = 1'b0;
            sum_src_d  = ST_IDLE;
        end

        lms_en_d = (state_d == ST_ACQUIRE) || (state_d == ST_TRACK);
        mu_d     = lms_en_d ? (mu_cap_d >> gear_d) : '0;
        locked_d = (state_d == ST_FREEZE);
    end

    // State, counters and registered outputs
    always_ff @(posedge clockdsp or posedge soft_reset) begin
        if (soft_reset) begin
            state_q    <= ST_IDLE;
            gear_q     <= '0;
            gear_cnt_q <= '0;
            mu_cap_q   <= '0;
            win_cnt_q  <= '0;
            acc_q      <= '0;
            sum_q      <= '0;
            sum_vld_q  <= 1'b0;
            sum_src_q  <= ST_IDLE;
            mu_q       <= '0;
            lms_en_q   <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            gear_q     <= gear_d;
            gear_cnt_q <= gear_cnt_d;
            mu_cap_q   <= mu_cap_d;
            win_cnt_q  <= win_cnt_d;
            acc_q      <= acc_d;
            sum_q      <= sum_d;
            sum_vld_q  <= sum_vld_d;
            sum_src_q  <= sum_src_d;
            mu_q       <= mu_d;
            lms_en_q   <= lms_en_d;
            locked_q   <= locked_d;
        end
    end

    assign o_mu          = mu_q;
    assign o_lms_en      = lms_en_q;
    assign o_state       = state_q;
    assign o_gear        = gear_q;
    assign o_locked      = locked_q;
    assign o_err_sum     = sum_q;
    assign o_err_sum_vld = sum_vld_q;

endmodule

// File: tb/tb_lms_gear_ctrl.sv
// Testbench for lms_gear_ctrl: vector table plus hand-written sequences,
// expectations queued when stimulus is driven and compared after the edge.
module tb_lms_gear_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [7:0]  err = '0;
    logic [7:0]  mu_init = 8'h80;
    logic [19:0] gear_len = 20'd4;
    logic [11:0] fthr = 12'd64;
    logic [11:0] rthr = 12'd512;

    logic [7:0]  o_mu;
    logic        o_lms_en;
    logic [1:0]  o_state;
    logic [1:0]  o_gear;
    logic        o_locked;
    logic [11:0] o_err_sum;
    logic        o_err_sum_vld;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic       en;
        logic       start;
        logic       stop;
        logic [7:0] err;
        logic [1:0] st;
        logic [1:0] gear;
        logic       chk_gear;
        logic [7:0] mu;
        logic       lms_en;
        logic       locked;
        logic       vld;
        logic       chk_sum;
        logic [11:0] sum;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[0:51];

    lms_gear_ctrl #(
        .ERR_BW   (8),
        .MU_BW    (8),
        .CNT_BW   (20),
        .N_GEARS  (4),
        .WIN_LOG2 (4)
    ) dut (
        .clockdsp      (clk),
        .soft_reset    (rst),
        .i_en          (en),
        .i_start       (start),
        .i_stop        (stop),
        .i_error       (err),
        .i_mu_init     (mu_init),
        .i_gear_len    (gear_len),
        .i_freeze_thr  (fthr),
        .i_relock_thr  (rthr),
        .o_mu          (o_mu),
        .o_lms_en      (o_lms_en),
        .o_state       (o_state),
        .o_gear        (o_gear),
        .o_locked      (o_locked),
        .o_err_sum     (o_err_sum),
        .o_err_sum_vld (o_err_sum_vld)
    );

    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic e, input logic s, input logic p,
                                input logic [7:0] er, input logic [1:0] st,
                                input logic [1:0] g, input logic [7:0] m);
        vec_t v;
        v.en = e; v.start = s; v.stop = p; v.err = er;
        v.st = st; v.gear = g; v.chk_gear = 1'b1; v.mu = m;
        v.lms_en = (st == 2'd1) || (st == 2'd2);
        v.locked = (st == 2'd3);
        v.vld = 1'b0; v.chk_sum = 1'b0; v.sum = '0;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string nm);
        vec_t x;
        @(negedge clk);
        en = v.en; start = v.start; stop = v.stop; err = v.err;
        sb.push_back(v);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk({nm, ".mu"}, 32'(o_mu), 32'(x.mu));
        chk({nm, ".lms_en"}, 32'(o_lms_en), 32'(x.lms_en));
        chk({nm, ".state"}, 32'(o_state), 32'(x.st));
        if (x.chk_gear) chk({nm, ".gear"}, 32'(o_gear), 32'(x.gear));
        chk({nm, ".locked"}, 32'(o_locked), 32'(x.locked));
        chk({nm, ".vld"}, 32'(o_err_sum_vld), 32'(x.vld));
        if (x.chk_sum) chk({nm, ".sum"}, 32'(o_err_sum), 32'(x.sum));
    endtask

    initial begin
        vec_t v;

        // Acquire (gear_len 4) -> track (+2 error) -> freeze (-128 error) -> relock -> stop
        for (int k = 0; k < 52; k++) begin
            logic [7:0] er;
            if (k >= 17 && k <= 32)      er = 8'd2;
            else if (k >= 33 && k <= 49) er = 8'h80;
            else                         er = 8'd0;
            if (k < 16)       tbl[k] = mk(1'b1, k == 0, 1'b0, er, 2'd1, 2'(k / 4), 8'h80 >> (k / 4));
            else if (k <= 32) tbl[k] = mk(1'b1, 1'b0, 1'b0, er, 2'd2, 2'd3, 8'h10);
            else if (k <= 49) tbl[k] = mk(1'b1, 1'b0, 1'b0, er, 2'd3, 2'd0, 8'h00);
            else if (k == 50) tbl[k] = mk(1'b1, 1'b0, 1'b0, er, 2'd1, 2'd0, 8'h80);
            else              tbl[k] = mk(1'b1, 1'b0, 1'b1, er, 2'd0, 2'd0, 8'h00);
            if (k >= 33 && k <= 49) tbl[k].chk_gear = 1'b0;
            tbl[k].vld     = (k == 16) || (k == 32) || (k == 49);
            tbl[k].chk_sum = tbl[k].vld;
            tbl[k].sum     = (k == 32) ? 12'd32 : (k == 49) ? 12'd2048 : 12'd0;
        end

        // Reset state
        #2;
        chk("rst.mu", 32'(o_mu), 0);
        chk("rst.lms_en", 32'(o_lms_en), 0);
        chk("rst.state", 32'(o_state), 0);
        chk("rst.gear", 32'(o_gear), 0);
        chk("rst.locked", 32'(o_locked), 0);
        chk("rst.sum", 32'(o_err_sum), 0);
        chk("rst.vld", 32'(o_err_sum_vld), 0);
        #10;
        rst = 1'b0;

        for (int k = 0; k < 52; k++) apply(tbl[k], $sformatf("tbl%0d", k));

        // Start and stop together in IDLE: stop wins
        apply(mk(1'b1, 1'b1, 1'b1, 8'd0, 2'd0, 2'd0, 8'h00), "ss_same");
        apply(mk(1'b1, 1'b0, 1'b0, 8'd0, 2'd0, 2'd0, 8'h00), "ss_idle");

        // i_en every other cycle: each gear spans 8 cycles; later mu_init ignored
        fthr = 12'd0;
        apply(mk(1'b0, 1'b1, 1'b0, 8'd0, 2'd1, 2'd0, 8'h80), "half_start");
        mu_init = 8'hFF;
        for (int c = 1; c <= 32; c++) begin
            if (c < 32) v = mk(c % 2 == 0, 1'b0, 1'b0, 8'd0, 2'd1, 2'(c / 8), 8'h80 >> (c / 8));
            else        v = mk(1'b1, 1'b0, 1'b0, 8'd0, 2'd2, 2'd3, 8'h10);
            if (c == 32) begin
                v.vld = 1'b1; v.chk_sum = 1'b1; v.sum = 12'd0;
            end
            apply(v, $sformatf("half%0d", c));
        end
        apply(mk(1'b0, 1'b0, 1'b1, 8'd0, 2'd0, 2'd0, 8'h00), "half_stop");

        // gear_len 0: one enabled sample per gear, then stop from TRACK
        mu_init = 8'h80;
        gear_len = 20'd0;
        apply(mk(1'b1, 1'b1, 1'b0, 8'd0, 2'd1, 2'd0, 8'h80), "g0_start");
        for (int c = 1; c <= 4; c++) begin
            if (c < 4) v = mk(1'b1, 1'b0, 1'b0, 8'd0, 2'd1, 2'(c), 8'h80 >> c);
            else       v = mk(1'b1, 1'b0, 1'b0, 8'd0, 2'd2, 2'd3, 8'h10);
            apply(v, $sformatf("g0_%0d", c));
        end
        apply(mk(1'b1, 1'b0, 1'b1, 8'd0, 2'd0, 2'd0, 8'h00), "track_stop");

        // Asynchronous soft_reset in gear 2, then restart with a new mu_init
        gear_len = 20'd4;
        apply(mk(1'b1, 1'b1, 1'b0, 8'd0, 2'd1, 2'd0, 8'h80), "ar_start");
        for (int c = 1; c <= 8; c++)
            apply(mk(1'b1, 1'b0, 1'b0, 8'd0, 2'd1, 2'(c / 4), 8'h80 >> (c / 4)), $sformatf("ar%0d", c));
        #2;
        rst = 1'b1;
        #1;
        chk("arst.mu", 32'(o_mu), 0);
        chk("arst.lms_en", 32'(o_lms_en), 0);
        chk("arst.state", 32'(o_state), 0);
        chk("arst.gear", 32'(o_gear), 0);
        @(negedge clk);
        rst = 1'b0;
        mu_init = 8'h60;
        apply(mk(1'b1, 1'b1, 1'b0, 8'd0, 2'd1, 2'd0, 8'h60), "re_start");
        for (int c = 1; c <= 4; c++)
            apply(mk(1'b1, 1'b0, 1'b0, 8'd0, 2'd1, 2'(c / 4), 8'h60 >> (c / 4)), $sformatf("re%0d", c));

        chk("sb_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
